fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end that consumes the execute stage's branch/jump resolution (pcsrc, jumpaddress).
- Owns the PC and issues word fetches to instruction memory over a request/grant/response handshake.
- Buffers returned instructions in a small FIFO and presents them, tagged with their PC, to decode over valid/ready.
- Redirects flush the FIFO and discard stale in-flight responses.

Parameters:
- D_WIDTH, 32, address/instruction width.
- RESET_VECTOR, 32'h0000_0000, PC after reset.
- BUF_DEPTH, 2, instruction FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pcsrc  in  1  redirect request from execute, single-cycle qualifier.
- jumpaddress  in  D_WIDTH  redirect target, valid when pcsrc=1.
- imem_req  out  1  fetch request.
- imem_addr  out  D_WIDTH  fetch address (= PC), held stable while imem_req=1 and imem_gnt=0.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; at least 1 cycle after gnt.
- imem_rdata  in  D_WIDTH  response instruction.
- instr_valid  out  1  FIFO head valid.
- instr  out  D_WIDTH  FIFO head instruction.
- prog_addr  out  D_WIDTH  PC of FIFO head.
- instr_ready  in  1  decode accepts head when instr_valid=1.
- misalign  out  1  one-cycle pulse: redirect target had [1:0]!=0.

Behaviour:
- Reset (async assert, sync release):
  - PC=RESET_VECTOR; FIFO empty; state=FETCH.
  - imem_req=0, instr_valid=0, instr=0, prog_addr=0, misalign=0.
  - imem_req may rise in the first cycle after rst_n deasserts.
- At most one outstanding request.
- imem_req=1 only in FETCH, with count + outstanding < BUF_DEPTH and no pcsrc this cycle.
- FSM states:
  - FETCH: req asserted per the rule above.
    - gnt=1 -> WAIT; PC<=PC+4 (modulo 2^D_WIDTH, 32'hFFFF_FFFC wraps to 0).
  - WAIT: req=0.
    - rvalid=1 -> push {rdata, addr of granted request}; -> FETCH.
  - DRAIN: a stale request is outstanding; req=0.
    - rvalid=1 -> discard; -> FETCH.
- Redirect (pcsrc=1) has priority over all other events that cycle:
  - PC <= {jumpaddress[D_WIDTH-1:2],2'b00}; FIFO flushed (count=0); a decode pop in the same cycle is ignored.
  - misalign <= |jumpaddress[1:0] next cycle, for one cycle.
  - State transitions on redirect:
    - from FETCH with gnt=1 that cycle -> DRAIN (grant was for the old PC);
    - from FETCH without gnt -> FETCH;
    - from WAIT with rvalid=0 -> DRAIN;
    - from WAIT with rvalid=1 -> FETCH, response dropped;
    - from DRAIN with rvalid=1 -> FETCH; DRAIN with rvalid=0 -> DRAIN.
  - imem_req forced 0 in the redirect cycle; first fetch of target is next cycle at earliest.
- FIFO:
  - Registered outputs; a push in cycle N is visible on instr_valid/instr/prog_addr in N+1 if the FIFO was empty.
  - Simultaneous push and pop allowed at any count, including full.
  - Pop only when instr_valid & instr_ready.
  - Overflow is impossible by construction; an assertion checks push never occurs at full without pop.
  - When empty: instr_valid=0; instr/prog_addr hold last value (don't care).
- Steady state with gnt tied 1 and 1-cycle response: one instruction per 2 cycles.
- Reset mid-operation: all state cleared immediately; any later rvalid from a pre-reset request is ignored (state FETCH, outstanding=0).

Decomposition:
- Shared package holds:
  - fetch_state_e {FETCH, WAIT, DRAIN};
  - INSTR_BYTES=4;
  - RV_NOP=32'h0000_0013 (used by the bench).
- One sub-module, fetch_fifo:
  - parameterised DEPTH/width; push, pop, flush, count, full/empty;
  - pointer-based, wrap via DEPTH power-of-2.
- PC/FSM/redirect logic stays in fetch_unit.

Test Plan:
- Reset then sequential fetch, gnt=1, 1-cycle rvalid, instr_ready=1 -> imem_addr sequence 0x0,0x4,0x8; prog_addr 0x0,0x4,0x8 with matching rdata; instr_valid first high 2 cycles after first req.
- Backpressure, instr_ready=0 -> exactly 2 entries buffered, then imem_req stays 0; release ready -> fetching resumes at 0x8, no entry lost or duplicated.
- Redirect while WAIT: pcsrc=1, jumpaddress=0x100 -> stale rvalid dropped (DRAIN), next imem_addr=0x100, FIFO empty the cycle after redirect, first delivered prog_addr=0x100.
- Redirect on same cycle as gnt for 0x8 -> 0x8 response discarded, next request 0x40 (target); pcsrc coincident with rvalid in WAIT -> response not pushed.
- Misaligned target jumpaddress=0x203 -> misalign pulses 1 cycle, imem_addr=0x200.
- PC wrap: RESET_VECTOR=32'hFFFF_FFFC -> second fetch address 0x0; rst_n asserted while in WAIT -> all outputs 0 immediately, later rvalid not pushed.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch front end.
//   fetch_state_e : fetch FSM states
//                   FETCH = may issue a request
//                   WAIT  = waiting for the granted fetch's response
//                   DRAIN = waiting for a stale response to discard
//   INSTR_BYTES   : PC increment per fetched instruction word
//   RV_NOP        : canonical RISC-V nop (addi x0,x0,0), handy as filler data
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   localparam int          INSTR_BYTES = 4;
   localparam logic [31:0] RV_NOP      = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small pointer-based FIFO holding fetched {pc, instruction} entries.
// DEPTH must be a power of two, so the pointers wrap naturally.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   flush        drop all entries (wins over push and pop)
//   push, wdata  write an entry
//   pop          consume the head (ignored when empty)
//   rdata        head entry, taken straight from storage flops
//   count        number of valid entries
//   full, empty  occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic [DEPTH-1:0] wr_en;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~flush;
   assign do_pop  = pop & ~flush & (count_reg != '0);

   // One-hot write enable per storage slot
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
         assign wr_en[gi] = do_push & (wr_ptr_reg == PTR_W'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en[i]) begin
               mem_reg[i] <= wdata;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Head is a mux of flops; after the last pop it shows stale data (don't care)
   assign rdata = mem_reg[rd_ptr_reg];
   assign count = count_reg;
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end: owns the PC, issues one word fetch at a time
// over a req/gnt/rvalid handshake, buffers responses in a FIFO and hands them
// to decode with their PC. A redirect from execute flushes the FIFO and turns
// any in-flight response into one to be discarded.
// Ports:
//   clk, rst_n                    clock / asynchronous active-low reset
//   pcsrc, jumpaddress            redirect request and target
//   imem_req, imem_addr           fetch request and word address (= PC)
//   imem_gnt                      request accepted
//   imem_rvalid, imem_rdata       fetch response
//   instr_valid, instr, prog_addr FIFO head and its PC
//   instr_ready                   decode accepts the head
//   misalign                      one-cycle pulse: redirect target not word aligned
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                 D_WIDTH      = 32,
   parameter logic [D_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                 BUF_DEPTH    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               pcsrc,
   input  logic [D_WIDTH-1:0] jumpaddress,
   output logic               imem_req,
   output logic [D_WIDTH-1:0] imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [D_WIDTH-1:0] imem_rdata,
   output logic               instr_valid,
   output logic [D_WIDTH-1:0] instr,
   output logic [D_WIDTH-1:0] prog_addr,
   input  logic               instr_ready,
   output logic               misalign
);

   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   fetch_state_e         state_reg;
   logic [D_WIDTH-1:0]   pc_reg;
   logic [D_WIDTH-1:0]   req_addr_reg;   // address of the granted, outstanding fetch
   logic                 misalign_reg;

   logic                 outstanding;
   logic [D_WIDTH-1:0]   redirect_pc;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;
   logic [2*D_WIDTH-1:0] fifo_wdata;
   logic [2*D_WIDTH-1:0] fifo_rdata;

   assign outstanding = (state_reg != FETCH);
   assign redirect_pc = {jumpaddress[D_WIDTH-1:2], 2'b00};

   // Only fetch when the buffer can absorb the response. rst_n gates the
   // request so it is low for the whole time reset is held.
   assign imem_req = rst_n & (state_reg == FETCH) & ~pcsrc &
                     (({1'b0, fifo_count} + {{CNT_W{1'b0}}, outstanding}) < (CNT_W+1)'(BUF_DEPTH));
   assign imem_addr = pc_reg;

   // A response arriving with a redirect belongs to the old path: drop it.
   // Same for a decode pop, since the flush empties the FIFO anyway.
   assign fifo_push  = (state_reg == WAIT) & imem_rvalid & ~pcsrc;
   assign fifo_pop   = instr_valid & instr_ready & ~pcsrc;
   assign fifo_wdata = {req_addr_reg, imem_rdata};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= FETCH;
         pc_reg       <= RESET_VECTOR;
         req_addr_reg <= '0;
         misalign_reg <= 1'b0;
      end else begin
         misalign_reg <= pcsrc & (|jumpaddress[1:0]);
         if (pcsrc) begin
            pc_reg <= redirect_pc;
            case (state_reg)
               // A grant seen now was for the old PC; its response must be drained
               FETCH:   state_reg <= imem_gnt    ? DRAIN : FETCH;
               WAIT,
               DRAIN:   state_reg <= imem_rvalid ? FETCH : DRAIN;
               default: state_reg <= FETCH;
            endcase
         end else begin
            case (state_reg)
               FETCH: begin
                  if (imem_req && imem_gnt) begin
                     state_reg    <= WAIT;
                     req_addr_reg <= pc_reg;
                     pc_reg       <= pc_reg + D_WIDTH'(INSTR_BYTES);
                  end
               end
               WAIT,
               DRAIN: begin
                  if (imem_rvalid) begin
                     state_reg <= FETCH;
                  end
               end
               default: state_reg <= FETCH;
            endcase
         end
      end
   end

   fetch_fifo #(
      .DEPTH (BUF_DEPTH),
      .WIDTH (2*D_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (pcsrc),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign instr_valid = ~fifo_empty;
   assign prog_addr   = fifo_rdata[2*D_WIDTH-1:D_WIDTH];
   assign instr       = fifo_rdata[D_WIDTH-1:0];
   assign misalign    = misalign_reg;

   // The request throttle must make overflow unreachable
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                   !(fifo_push && fifo_full && !fifo_pop));

endmodule
